// File: rtl/fir_mac_engine.sv
// FIR compute core: keeps an 11-deep circular sample history in data RAM and
// runs one tap-by-tap multiply-accumulate pass per accepted input sample.
module fir_mac_engine #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ap_start,
   input  logic                   ap_done_clr,
   input  logic [31:0]            data_length,
   output logic                   ap_done,
   output logic                   ap_idle,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tvalid,
   output logic                   ss_tready,
   input  logic                   ss_tlast,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tvalid,
   input  logic                   sm_tready,
   output logic                   sm_tlast,
   output logic                   tap_EN,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   output logic [3:0]             data_WE,
   output logic                   data_EN,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   input  logic [pDATA_WIDTH-1:0] data_Do
);

   localparam int          IW         = $clog2(Tape_Num + 1);
   localparam logic [IW-1:0] K_LAST_CLR = IW'(Tape_Num - 1);
   localparam logic [IW-1:0] K_LAST_MAC = IW'(Tape_Num);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_X, S_MAC, S_OUT, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            len_q, len_d;
   logic [31:0]            count_q, count_d;
   logic [IW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [IW-1:0]          k_q, k_d;
   logic [pDATA_WIDTH-1:0] acc_q, acc_d;
   logic                   done_q, done_d;
   logic                   idle_q, idle_d;
   logic [IW-1:0]          rd_idx;
   logic [pDATA_WIDTH-1:0] prod;
   logic                   unused_tlast;

   function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [IW-1:0] idx);
      return pADDR_WIDTH'({idx, 2'b00});
   endfunction

   assign unused_tlast = ss_tlast;
   assign ap_done      = done_q;
   assign ap_idle      = idle_q;

   // Newest sample sits at wr_ptr; tap k pairs with the sample k steps older.
   // The 4-bit wrap of wr_ptr+11-k is harmless because the true result is < 11.
   assign rd_idx = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : (wr_ptr_q + IW'(Tape_Num) - k_q);
   // The low word of a two's-complement product is the same signed or unsigned.
   assign prod   = tap_Do * data_Do;

   // NOTE: every comb output/next-state gets a default first so no latches are inferred.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      k_d      = k_q;
      acc_d    = acc_q;
      done_d   = ap_done_clr ? 1'b0 : done_q;
      idle_d   = idle_q;

      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tdata  = '0;
      sm_tlast  = 1'b0;
      tap_EN    = 1'b0;
      tap_A     = '0;
      data_EN   = 1'b0;
      data_WE   = 4'h0;
      data_A    = '0;
      data_Di   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               len_d   = data_length;
               done_d  = 1'b0;
               idle_d  = 1'b0;
               k_d     = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            data_EN = 1'b1;
            data_WE = 4'hf;
            data_A  = byte_addr(k_q);
            k_d     = k_q + 1'b1;
            if (k_q == K_LAST_CLR) begin
               k_d      = '0;
               wr_ptr_d = '0;
               count_d  = '0;
               state_d  = (len_q == 32'd0) ? S_DONE : S_WAIT_X;
            end
         end
         S_WAIT_X: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               data_EN = 1'b1;
               data_WE = 4'hf;
               data_A  = byte_addr(wr_ptr_q);
               data_Di = ss_tdata;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            // Reads issue on k=0..10; RAM data for read k-1 arrives on cycle k.
            if (k_q != K_LAST_MAC) begin
               tap_EN  = 1'b1;
               tap_A   = byte_addr(k_q);
               data_EN = 1'b1;
               data_A  = byte_addr(rd_idx);
            end
            if (k_q != '0) acc_d = acc_q + prod;
            k_d = k_q + 1'b1;
            if (k_q == K_LAST_MAC) begin
               k_d     = '0;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            sm_tvalid = 1'b1;
            sm_tdata  = acc_q;
            sm_tlast  = (count_q == len_q - 32'd1);
            if (sm_tready) begin
               wr_ptr_d = (wr_ptr_q == K_LAST_CLR) ? '0 : wr_ptr_q + 1'b1;
               count_d  = count_q + 32'd1;
               state_d  = (count_q + 32'd1 == len_q) ? S_DONE : S_WAIT_X;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            idle_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         idle_q   <= idle_d;
      end
   end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: behavioural tap/data RAMs, randomized
// stream stimulus with gaps and back-pressure, and a direct-form FIR reference.
module tb_fir_mac_engine;

   localparam int TN = 11;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic        ap_start, ap_done_clr, ap_done, ap_idle;
   logic [31:0] data_length;
   logic [31:0] ss_tdata, sm_tdata;
   logic        ss_tvalid, ss_tready, ss_tlast;
   logic        sm_tvalid, sm_tready, sm_tlast;
   logic        tap_EN, data_EN;
   logic [11:0] tap_A, data_A;
   logic [31:0] tap_Do, data_Do, data_Di;
   logic [3:0]  data_WE;

   int errors = 0;
   int checks = 0;

   logic [31:0] tap_mem  [16];
   logic [31:0] data_mem [16];
   logic [31:0] xs [$];
   logic [31:0] got_y [$];
   logic        got_last [$];

   always #5 axis_clk = ~axis_clk;

   fir_mac_engine dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .ap_start    (ap_start),
      .ap_done_clr (ap_done_clr),
      .data_length (data_length),
      .ap_done     (ap_done),
      .ap_idle     (ap_idle),
      .ss_tdata    (ss_tdata),
      .ss_tvalid   (ss_tvalid),
      .ss_tready   (ss_tready),
      .ss_tlast    (ss_tlast),
      .sm_tdata    (sm_tdata),
      .sm_tvalid   (sm_tvalid),
      .sm_tready   (sm_tready),
      .sm_tlast    (sm_tlast),
      .tap_EN      (tap_EN),
      .tap_A       (tap_A),
      .tap_Do      (tap_Do),
      .data_WE     (data_WE),
      .data_EN     (data_EN),
      .data_A      (data_A),
      .data_Di     (data_Di),
      .data_Do     (data_Do)
   );

   always @(posedge axis_clk) if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];

   always @(posedge axis_clk) begin
      if (data_EN) begin
         for (int b = 0; b < 4; b++)
            if (data_WE[b]) data_mem[data_A[5:2]][8*b +: 8] <= data_Di[8*b +: 8];
         data_Do <= data_mem[data_A[5:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // y[n] = sum over k of tap[k] * x[n-k], samples before the run start count as zero.
   function automatic logic [31:0] ref_y(input int n);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < TN; k++)
         if (n - k >= 0) s = s + tap_mem[k] * xs[n - k];
      return s;
   endfunction

   task automatic set_taps(input int mode);
      for (int k = 0; k < 16; k++) begin
         case (mode)
            0:       tap_mem[k] = (k == 0) ? 32'd1 : 32'd0;
            1:       tap_mem[k] = (k < TN) ? 32'd1 : 32'd0;
            default: tap_mem[k] = (k < TN) ? 32'($signed($urandom_range(0, 200)) - 100) : 32'd0;
         endcase
      end
   endtask

   task automatic rand_xs(input int n);
      xs.delete();
      for (int i = 0; i < n; i++) xs.push_back(32'($signed($urandom_range(0, 2000)) - 1000));
   endtask

   task automatic pulse_start(input int len);
      @(negedge axis_clk);
      data_length = 32'(len);
      ap_start    = 1'b1;
      @(negedge axis_clk);
      ap_start    = 1'b0;
      check("start_busy", {30'd0, ap_done, ap_idle}, 32'd0);
   endtask

   // gap<0 -> random 0..3 idle cycles between samples; stall_idx output held off 5 cycles.
   task automatic run(input int len, input int gap, input int bp_pct, input int stall_idx);
      int          budget;
      int          cyc;
      int          stall_cnt;
      bit          prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      got_y.delete();
      got_last.delete();
      budget     = len * 60 + 100;
      cyc        = 0;
      stall_cnt  = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      pulse_start(len);
      fork
         begin
            for (int i = 0; i < len; i++) begin
               int g;
               int w;
               g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
               repeat (g) @(negedge axis_clk);
               ss_tvalid = 1'b1;
               ss_tdata  = xs[i];
               ss_tlast  = 1'($urandom_range(0, 1));
               w = 0;
               while (!ss_tready && w < 300) begin
                  @(negedge axis_clk);
                  w++;
               end
               if (!ss_tready) begin
                  check("feed_timeout", 32'd0, 32'd1);
                  i = len;
               end else begin
                  @(negedge axis_clk);
               end
               ss_tvalid = 1'b0;
               ss_tdata  = $urandom;
            end
         end
         begin
            while (!ap_done && cyc < budget) begin
               @(negedge axis_clk);
               cyc++;
               if (sm_tvalid && got_y.size() == stall_idx && stall_cnt < 5) begin
                  sm_tready = 1'b0;
                  stall_cnt++;
               end else begin
                  sm_tready = ($urandom_range(0, 99) >= bp_pct);
               end
               if (prev_stall) begin
                  check("hold_valid", {31'd0, sm_tvalid}, 32'd1);
                  check("hold_data", sm_tdata, prev_data);
                  check("hold_last", {31'd0, sm_tlast}, {31'd0, prev_last});
               end
               if (sm_tvalid) check("out_blocks_in", {31'd0, ss_tready}, 32'd0);
               if (sm_tvalid && sm_tready) begin
                  got_y.push_back(sm_tdata);
                  got_last.push_back(sm_tlast);
               end
               prev_stall = sm_tvalid && !sm_tready;
               prev_data  = sm_tdata;
               prev_last  = sm_tlast;
            end
            if (!ap_done) check("done_timeout", 32'd0, 32'd1);
         end
      join
      sm_tready = 1'b0;
      check("n_out", 32'(got_y.size()), 32'(len));
      for (int i = 0; i < got_y.size() && i < len; i++) begin
         check($sformatf("y[%0d]", i), got_y[i], ref_y(i));
         check($sformatf("tlast[%0d]", i), {31'd0, got_last[i]}, {31'd0, (i == len - 1)});
      end
      check("end_done_idle", {30'd0, ap_done, ap_idle}, 32'd3);
   endtask

   initial begin
      axis_rst_n  = 1'b0;
      ap_start    = 1'b0;
      ap_done_clr = 1'b0;
      data_length = '0;
      ss_tdata    = '0;
      ss_tvalid   = 1'b0;
      ss_tlast    = 1'b0;
      sm_tready   = 1'b0;
      for (int i = 0; i < 16; i++) data_mem[i] = 32'hDEAD_0000 + 32'(i);
      set_taps(0);

      repeat (3) @(negedge axis_clk);
      check("rst_idle_done", {30'd0, ap_done, ap_idle}, 32'd1);
      check("rst_handshake", {30'd0, ss_tready, sm_tvalid}, 32'd0);
      check("rst_sm", sm_tdata | {31'd0, sm_tlast}, 32'd0);
      check("rst_ram_ctl", {26'd0, tap_EN, data_EN, data_WE}, 32'd0);
      check("rst_addr", {8'd0, tap_A, data_A}, 32'd0);
      axis_rst_n = 1'b1;

      // identity filter over stale RAM contents
      xs = '{32'd7, 32'hFFFF_FFFD, 32'd100, 32'd0};
      run(4, 0, 0, -1);
      check("ident_y1_const", got_y.size() > 1 ? got_y[1] : 32'hx, 32'hFFFF_FFFD);

      @(negedge axis_clk);
      ap_done_clr = 1'b1;
      @(negedge axis_clk);
      ap_done_clr = 1'b0;
      check("done_clr", {30'd0, ap_done, ap_idle}, 32'd1);

      // moving sum with history wrap; also proves the restart clears old history
      set_taps(1);
      xs.delete();
      for (int i = 1; i <= 12; i++) xs.push_back(32'(i));
      run(12, 0, 0, -1);
      check("msum_last_const", got_y.size() == 12 ? got_y[11] : 32'hx, 32'd77);

      // back-pressure on output 2 plus fixed input gaps, then random mix
      rand_xs(8);
      run(8, 3, 0, 1);
      rand_xs(10);
      run(10, -1, 40, -1);

      // signed and wrap-around arithmetic
      set_taps(0);
      tap_mem[0] = 32'hFFFF_FFFF;
      xs = '{32'd5};
      run(1, 0, 0, -1);
      check("neg_tap_const", got_y.size() == 1 ? got_y[0] : 32'hx, 32'hFFFF_FFFB);
      tap_mem[0] = 32'h7FFF_FFFF;
      xs = '{32'd2};
      run(1, 0, 0, -1);
      check("ovf_const", got_y.size() == 1 ? got_y[0] : 32'hx, 32'hFFFF_FFFE);

      // zero-length run
      xs.delete();
      run(0, 0, 0, -1);

      // random taps and data
      for (int r = 0; r < 3; r++) begin
         set_taps(2);
         rand_xs(int'($urandom_range(1, 15)));
         run(xs.size(), -1, 30, -1);
      end

      // asynchronous reset in MAC cycle 5, then a clean run
      set_taps(2);
      rand_xs(3);
      pulse_start(3);
      ss_tvalid = 1'b1;
      ss_tdata  = xs[0];
      for (int w = 0; w < 40 && !ss_tready; w++) @(negedge axis_clk);
      check("pre_rst_ready", {31'd0, ss_tready}, 32'd1);
      @(posedge axis_clk);
      #1 ss_tvalid = 1'b0;
      repeat (5) @(posedge axis_clk);
      #1 axis_rst_n = 1'b0;
      #1;
      check("mid_rst_idle_done", {30'd0, ap_done, ap_idle}, 32'd1);
      check("mid_rst_handshake", {30'd0, ss_tready, sm_tvalid}, 32'd0);
      check("mid_rst_ram_ctl", {26'd0, tap_EN, data_EN, data_WE}, 32'd0);
      check("mid_rst_addr", {8'd0, tap_A, data_A}, 32'd0);
      repeat (2) @(negedge axis_clk);
      axis_rst_n = 1'b1;
      run(3, -1, 20, -1);

      repeat (3) @(negedge axis_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Compute core of the FIR accelerator.
- Runs after the AXI4-Lite config path has loaded taps into tap RAM and has produced ap_start and data_length.
- Consumes the input sample stream, keeps an 11-entry circular history of samples in data RAM, and runs one tap-by-tap MAC pass per sample.
- Drives each result onto the AXI4-Stream master output and reports ap_done/ap_idle back to the config block.

Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, sample, tap and result width
- Tape_Num, 11, number of taps and history depth

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  reset; asynchronous, active-low
- ap_start  in  1  one-cycle start pulse from config block
- ap_done_clr  in  1  one-cycle pulse; clears ap_done (config read of status)
- data_length  in  32  number of samples to process, sampled on ap_start
- ap_done  out  1  run complete
- ap_idle  out  1  engine idle
- ss_tdata  in  32  input sample
- ss_tvalid  in  1  input valid
- ss_tready  out  1  input ready
- ss_tlast  in  1  accepted and ignored; data_length governs run length
- sm_tdata  out  32  filter output y
- sm_tvalid  out  1  output valid
- sm_tready  in  1  output ready
- sm_tlast  out  1  marks final output
- tap_EN  out  1  tap RAM enable (read only)
- tap_A  out  12  tap RAM byte address
- tap_Do  in  32  tap RAM read data, 1-cycle latency
- data_WE  out  4  data RAM byte write enables
- data_EN  out  1  data RAM enable
- data_A  out  12  data RAM byte address
- data_Di  out  32  data RAM write data
- data_Do  in  32  data RAM read data, 1-cycle latency

Behaviour:
- Reset (async assert, sync release). State IDLE; ap_idle=1, ap_done=0, ss_tready=0, sm_tvalid=0, sm_tlast=0, sm_tdata=0, all RAM enables/WE=0, addresses 0, wr_ptr=0, count=0, acc=0.
- States: IDLE, CLEAR, WAIT_X, MAC, OUT, DONE.
- IDLE:
  - On ap_start, latch data_length into len, clear ap_done, drop ap_idle.
  - Next state is CLEAR.
  - ap_start in any other state is ignored.
- CLEAR:
  - 11 cycles. Write 0 to data RAM addresses 0x00,0x04..0x28 (data_EN=1, data_WE=4'hf).
  - Set wr_ptr=0, count=0.
  - Then go to DONE if len==0, else WAIT_X.
- WAIT_X:
  - ss_tready=1.
  - On ss_tvalid&ss_tready, in the same cycle: data_A=4*wr_ptr, data_Di=ss_tdata, data_WE=4'hf. Clear acc. Go to MAC.
- MAC:
  - 12 cycles.
  - Cycles k=0..10 issue reads: tap_A=4*k, data_A=4*((wr_ptr-k) mod 11), WE=0.
  - Cycles 1..11 add tap_Do*data_Do to acc.
  - Then go to OUT.
- Arithmetic:
  - Signed 32x32 multiply; keep the low 32 bits.
  - Accumulate modulo 2^32 with no saturation.
- OUT:
  - sm_tvalid=1, sm_tdata=acc, sm_tlast=(count==len-1).
  - sm_tdata and sm_tlast hold stable while sm_tready=0.
  - ss_tready=0 (back-pressure propagates upstream).
  - On handshake: wr_ptr wraps 10->0, else +1; count+1.
  - If count+1==len go to DONE, else WAIT_X.
  - sm_tvalid drops the cycle after the handshake.
- DONE: set ap_done=1 and ap_idle=1, then go to IDLE.
- ap_done:
  - Stays 1 until ap_done_clr or the next ap_start.
  - If ap_done_clr arrives in the same cycle ap_done sets, set wins.
- Per-sample throughput: 1 (accept) + 12 (MAC) + 1 (OUT min) = 14 cycles.
- Tap RAM is never written by this block. The config block owns tap writes and must not start a run mid-write.

Test Plan:
- Identity: taps [1,0×10]; len=4; x=7,-3,100,0 -> y=7,0xFFFFFFFD,100,0; sm_tlast only on 4th output; ap_done=1, ap_idle=1 afterwards.
- Moving sum: taps all 1; len=12; x=1..12 -> y=1,3,6,...,66,77 (history wraps; x=1 evicted); count of outputs=12.
- Back-pressure: sm_tready=0 for 5 cycles on output 2 -> sm_tdata stable, ss_tready=0 throughout, no sample lost; ss_tvalid gaps of 3 cycles -> same outputs.
- Signed/overflow: tap0=-1, x=5 -> 0xFFFFFFFB; tap0=0x7FFFFFFF, x=2 -> 0xFFFFFFFE.
- Boundaries:
  - len=0 -> ap_done set after CLEAR with no sm_tvalid.
  - Second ap_start after ap_done with prior history -> first y uses zeros only.
  - ap_done_clr clears ap_done.
- Reset mid-MAC: assert axis_rst_n=0 during MAC cycle 5 -> outputs return to reset values immediately; next run yields correct y.
